// File: rtl/fib_arbiter.sv
// Round-robin arbiter that time-shares one Fibonacci engine among NUM_REQ requesters.
// Owns the engine start handshake and returns result, overflow and timeout to the winner.
module fib_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [OUTPUT_WIDTH-1:0]        resp_result,
  output logic                           resp_overflow,
  output logic                           resp_timeout,
  output logic                           busy,
  output logic                           fib_go,
  output logic [INPUT_WIDTH-1:0]         fib_n,
  input  logic [OUTPUT_WIDTH-1:0]        fib_result,
  input  logic                           fib_overflow,
  input  logic                           fib_done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESP} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        sel_q, sel_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [OUTPUT_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                    resp_overflow_q, resp_overflow_d;
  logic                    resp_timeout_q, resp_timeout_d;
  logic                    busy_q, busy_d;
  logic                    fib_go_q, fib_go_d;
  logic [INPUT_WIDTH-1:0]  fib_n_q, fib_n_d;
  logic                    ovf_base_q, ovf_base_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    pick_found;
  logic [PTR_W-1:0]        pick_idx;

  // First requester at or after ptr, wrapping around.
  always_comb begin : pick_c
    int pos;
    pick_found = 1'b0;
    pick_idx   = '0;
    pos        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_found && req[pos]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(pos);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    sel_d           = sel_q;
    grant_d         = grant_q;
    resp_valid_d    = '0;
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    resp_timeout_d  = resp_timeout_q;
    fib_go_d        = 1'b0;
    fib_n_d         = fib_n_q;
    ovf_base_d      = ovf_base_q;
    cnt_d           = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d    = pick_idx;
          grant_d  = ONE_HOT0 << pick_idx;
          fib_n_d  = req_n[int'(pick_idx)*INPUT_WIDTH +: INPUT_WIDTH];
          fib_go_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The engine flag is sticky, so only a 0->1 change during this job counts.
        ovf_base_d = fib_overflow;
        cnt_d      = '0;
        state_d    = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!fib_done) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          resp_result_d   = '0;
          resp_overflow_d = 1'b0;
          resp_timeout_d  = 1'b1;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (fib_done) begin
          resp_result_d   = fib_result;
          resp_overflow_d = fib_overflow & ~ovf_base_q;
          resp_timeout_d  = 1'b0;
          state_d         = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_result_d   = '0;
          resp_overflow_d = 1'b0;
          resp_timeout_d  = 1'b1;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (int'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RESP && state_q != RESP) resp_valid_d = grant_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      sel_q           <= '0;
      grant_q         <= '0;
      resp_valid_q    <= '0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_timeout_q  <= 1'b0;
      busy_q          <= 1'b0;
      fib_go_q        <= 1'b0;
      fib_n_q         <= '0;
      ovf_base_q      <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      sel_q           <= sel_d;
      grant_q         <= grant_d;
      resp_valid_q    <= resp_valid_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_timeout_q  <= resp_timeout_d;
      busy_q          <= busy_d;
      fib_go_q        <= fib_go_d;
      fib_n_q         <= fib_n_d;
      ovf_base_q      <= ovf_base_d;
      cnt_q           <= cnt_d;
    end
  end

  assign grant         = grant_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_timeout  = resp_timeout_q;
  assign busy          = busy_q;
  assign fib_go        = fib_go_q;
  assign fib_n         = fib_n_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Bench for fib_arbiter: behavioural Fibonacci engine, directed vector table,
// multi-cycle corner sequences and a randomized round-robin scoreboard.
module tb_fib_arbiter;
  localparam int NR = 4;
  localparam int IW = 6;
  localparam int OW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*IW-1:0]  req_n = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     resp_valid;
  logic [OW-1:0]     resp_result;
  logic              resp_overflow;
  logic              resp_timeout;
  logic              busy;
  logic              fib_go;
  logic [IW-1:0]     fib_n;
  logic [OW-1:0]     fib_result;
  logic              fib_overflow;
  logic              fib_done;

  fib_arbiter #(
    .NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_n(req_n), .grant(grant),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_timeout(resp_timeout), .busy(busy),
    .fib_go(fib_go), .fib_n(fib_n), .fib_result(fib_result),
    .fib_overflow(fib_overflow), .fib_done(fib_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fibref(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Engine model: done is a level cleared on go, overflow is sticky until reset.
  logic        eng_hang = 1'b0;
  logic        eng_run;
  int          eng_cnt;
  logic [63:0] eng_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fib_done     <= 1'b0;
      fib_result   <= '0;
      fib_overflow <= 1'b0;
      eng_run      <= 1'b0;
      eng_cnt      <= 0;
      eng_val      <= '0;
    end else if (fib_go) begin
      fib_done <= 1'b0;
      eng_run  <= 1'b1;
      eng_cnt  <= int'($urandom_range(0, 5));
      eng_val  <= fibref(int'(fib_n));
    end else if (eng_run && !eng_hang) begin
      if (eng_cnt == 0) begin
        fib_done   <= 1'b1;
        fib_result <= eng_val[31:0];
        if (eng_val[63:32] != 0) fib_overflow <= 1'b1;
        eng_run <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic do_job(input int idx, input int n, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_to, input int exp_lat);
    int go_cnt = 0;
    int go_t = -1;
    int t = 0;
    bit done = 1'b0;
    @(negedge clk);
    req[idx] = 1'b1;
    req_n[idx*IW +: IW] = IW'(n);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
      if (fib_go) begin
        go_cnt++;
        go_t = t;
        chk("job_grant", grant, 64'(1) << idx);
        chk("job_fib_n", fib_n, n);
        chk("job_busy", busy, 1);
        req_n[idx*IW +: IW] = IW'($urandom);
      end
      if (resp_valid != 0) begin
        chk("job_resp_valid", resp_valid, 64'(1) << idx);
        chk("job_result", resp_result, exp_res);
        chk("job_overflow", resp_overflow, exp_ovf);
        chk("job_timeout", resp_timeout, exp_to);
        chk("job_fib_n_stable", fib_n, n);
        if (exp_lat >= 0) chk("job_latency", t - go_t, exp_lat);
        req[idx] = 1'b0;
        done = 1'b1;
      end
    end
    chk("job_completed", done, 1);
    chk("job_go_pulses", go_cnt, 1);
    @(negedge clk);
    chk("idle_resp_valid", resp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    chk("idle_result_held", resp_result, exp_res);
  endtask

  int          s_idx[8];
  logic [31:0] s_res[8];

  task automatic seq_run(input int cnt, input bit hold);
    int g = 0;
    int r = 0;
    int gap = 0;
    int t = 0;
    logic [NR-1:0] pg = '0;
    while (r < cnt && t < 400) begin
      @(negedge clk);
      t++;
      if (grant != 0 && pg == 0) begin
        if (g > 0) chk("seq_idle_gap", gap, 1);
        if (g < cnt) chk("seq_grant_order", grant, 64'(1) << s_idx[g]);
        g++;
      end
      gap = (grant == 0) ? gap + 1 : 0;
      if (resp_valid != 0) begin
        chk("seq_resp_valid", resp_valid, 64'(1) << s_idx[r]);
        chk("seq_result", resp_result, s_res[r]);
        if (!hold) req = req & ~resp_valid;
        r++;
      end
      pg = grant;
    end
    chk("seq_completed", r, cnt);
    req = '0;
    @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    int          n;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];

  int          ptr_m;
  bit          sticky_m;
  bit          pend_ex;
  int          ex_sel;
  int          ex_n;
  int          jobs;
  int          s;
  int          p;
  logic [63:0] v;
  bit          vo;
  int          rv_seen;

  initial begin
    tbl[0] = '{2, 10, 32'd55, 1'b0};
    tbl[1] = '{3, 0, 32'd0, 1'b0};
    tbl[2] = '{0, 1, 32'd1, 1'b0};
    tbl[3] = '{1, 2, 32'd1, 1'b0};
    tbl[4] = '{2, 47, 32'd2971215073, 1'b0};
    tbl[5] = '{3, 48, 32'd512559680, 1'b1};
    tbl[6] = '{0, 5, 32'd5, 1'b0};
    tbl[7] = '{1, 6, 32'd8, 1'b0};
    tbl[8] = '{2, 9, 32'd34, 1'b0};
    tbl[9] = '{3, 12, 32'd144, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_overflow", resp_overflow, 0);
    chk("rst_timeout", resp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fib_go", fib_go, 0);
    chk("rst_fib_n", fib_n, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      do_job(tbl[i].idx, tbl[i].n, tbl[i].res, tbl[i].ovf, 1'b0, -1);

    // All four requesting continuously: strict rotation, one IDLE cycle between grants.
    req_n = {IW'(6), IW'(5), IW'(4), IW'(3)};
    s_idx[0] = 0; s_idx[1] = 1; s_idx[2] = 2; s_idx[3] = 3; s_idx[4] = 0;
    s_res[0] = 2; s_res[1] = 3; s_res[2] = 5; s_res[3] = 8; s_res[4] = 2;
    req = '1;
    seq_run(5, 1'b1);

    // Hung engine: ISSUE + one WAIT_CLR + sixteen WAIT_DONE cycles before RESP.
    eng_hang = 1'b1;
    do_job(1, 4, 32'd0, 1'b0, 1'b1, 18);
    eng_hang = 1'b0;
    do_job(2, 7, 32'd13, 1'b0, 1'b0, -1);

    // Reset in WAIT_DONE drops the job and clears ptr.
    eng_hang = 1'b1;
    @(negedge clk);
    req[3] = 1'b1;
    req_n[3*IW +: IW] = IW'(8);
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", resp_result, 0);
    chk("midrst_overflow", resp_overflow, 0);
    chk("midrst_timeout", resp_timeout, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_fib_go", fib_go, 0);
    chk("midrst_fib_n", fib_n, 0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eng_hang = 1'b0;
    rv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid != 0) rv_seen++;
    end
    chk("midrst_no_resp", rv_seen, 0);

    req_n[1*IW +: IW] = IW'(4);
    req_n[3*IW +: IW] = IW'(7);
    s_idx[0] = 1; s_idx[1] = 3;
    s_res[0] = 3; s_res[1] = 13;
    req = 4'b1010;
    seq_run(2, 1'b0);

    // Randomized traffic against a round-robin scoreboard.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    sticky_m = 1'b0;
    pend_ex = 1'b0;
    ex_sel = 0;
    ex_n = 0;
    jobs = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (fib_go) begin
        s = -1;
        for (int k = 0; k < NR; k++) begin
          p = (ptr_m + k) % NR;
          if (s < 0 && req[p]) s = p;
        end
        chk("rnd_grant", grant, (s < 0) ? 64'd0 : (64'(1) << s));
        if (s >= 0) begin
          ex_sel = s;
          ex_n = int'(req_n[s*IW +: IW]);
          chk("rnd_fib_n", fib_n, ex_n);
          req_n[s*IW +: IW] = IW'($urandom);
          pend_ex = 1'b1;
        end
      end
      if (resp_valid != 0) begin
        v = fibref(ex_n);
        vo = (v[63:32] != 0);
        chk("rnd_resp_valid", resp_valid, pend_ex ? (64'(1) << ex_sel) : 64'd0);
        chk("rnd_result", resp_result, v[31:0]);
        chk("rnd_overflow", resp_overflow, vo && !sticky_m);
        chk("rnd_timeout", resp_timeout, 0);
        sticky_m = sticky_m | vo;
        ptr_m = (ex_sel + 1) % NR;
        req[ex_sel] = 1'b0;
        pend_ex = 1'b0;
        jobs++;
      end
      if (c < 3500) begin
        for (int i = 0; i < NR; i++) begin
          if (!req[i] && !resp_valid[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_n[i*IW +: IW] = IW'($urandom_range(0, 50));
          end
        end
      end
    end
    chk("rnd_drained", req, 0);
    chk("rnd_enough_jobs", jobs > 50, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
